// File: rtl/score_disp_pkg.sv
// Shared types, sizes and the double-dabble step used by the score display scheduler.
package score_disp_pkg;

   typedef enum logic [1:0] {IDLE, PICK, CONV, SHOW} state_t;

   localparam int BCD_W    = 4;
   localparam int DD_STEPS = 8;

   // Work word is {hund, tens, ones, binary}; add 3 to any digit >= 5, then shift left by one.
   function automatic logic [19:0] dd_step(input logic [19:0] x);
      logic [19:0] t;
      t = x;
      if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
      if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
      if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
      return {t[18:0], 1'b0};
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 8-bit binary to 3-digit BCD converter: one double-dabble step per cycle.
module bin2bcd_seq
   import score_disp_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             start,
   input  logic [7:0]       din,
   output logic             done,
   output logic [BCD_W-1:0] hund,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   logic [19:0] work_q, work_d, step;
   logic [2:0]  cnt_q, cnt_d;
   logic        run_q, run_d;

   always_comb begin
      step   = dd_step(work_q);
      work_d = work_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      if (start) begin
         work_d = {12'd0, din};
         cnt_d  = 3'd0;
         run_d  = 1'b1;
      end else if (run_q) begin
         work_d = step;
         cnt_d  = cnt_q + 3'd1;
         if (cnt_q == 3'(DD_STEPS - 1)) run_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         work_q <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
      end
   end

   // Digits are the result of the step in flight, so the caller can register them on the last step.
   assign done = run_q && (cnt_q == 3'(DD_STEPS - 1));
   assign hund = step[19:16];
   assign tens = step[15:12];
   assign ones = step[11:8];

endmodule

// File: rtl/score_display_sched.sv
// Shares one 3-digit BCD display among NUM_CH latched 8-bit values, rotating round-robin.
module score_display_sched
   import score_disp_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DWELL  = 50_000_000,
   localparam int CW     = $clog2(NUM_CH)
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [NUM_CH-1:0]     Wr_En,
   input  logic [NUM_CH*8-1:0]   Wr_Data,
   input  logic                  Hold,
   output logic [BCD_W-1:0]      Bcd_Hund,
   output logic [BCD_W-1:0]      Bcd_Tens,
   output logic [BCD_W-1:0]      Bcd_Ones,
   output logic [CW-1:0]         Disp_Ch,
   output logic                  Disp_Valid,
   output logic                  Busy
);

   localparam int DW = $clog2(DWELL);
   localparam logic [DW-1:0] DW_MAX = DW'(DWELL - 1);

   state_t              state_q, state_d;
   logic [7:0]          val_q [NUM_CH];
   logic [7:0]          val_d [NUM_CH];
   logic [NUM_CH-1:0]   present_q, present_d;
   logic [CW-1:0]       rr_q, rr_d, pick_ch, snap_ch, idx;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic                refresh_q, refresh_d, recon_q, recon_d, found, start;
   logic [BCD_W-1:0]    hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
   logic [BCD_W-1:0]    cvt_hund, cvt_tens, cvt_ones;
   logic [CW-1:0]       ch_q, ch_d;
   logic                valid_q, valid_d, cvt_done;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++)
         val_d[i] = Wr_En[i] ? Wr_Data[8*i +: 8] : val_q[i];
      present_d = present_q | Wr_En;
   end

   // First present channel after the round-robin pointer, wrapping around.
   always_comb begin
      pick_ch = rr_q;
      found   = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = CW'((int'(rr_q) + k) % NUM_CH);
         if (!found && present_q[idx]) begin
            pick_ch = idx;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      dwell_d = dwell_q;
      recon_d = recon_q;
      start   = 1'b0;
      snap_ch = rr_q;
      case (state_q)
         IDLE: if (|present_q) state_d = PICK;
         PICK: begin
            start   = 1'b1;
            snap_ch = pick_ch;
            rr_d    = pick_ch;
            dwell_d = '0;
            recon_d = 1'b0;
            state_d = CONV;
         end
         CONV: begin
            // A refresh conversion keeps the dwell running so the channel's slot is not stretched.
            if (recon_q && dwell_q != DW_MAX) dwell_d = dwell_q + 1'b1;
            if (cvt_done) begin
               state_d = SHOW;
               recon_d = 1'b0;
            end
         end
         SHOW: begin
            if (dwell_q != DW_MAX) dwell_d = dwell_q + 1'b1;
            if (refresh_q) begin
               start   = 1'b1;
               recon_d = 1'b1;
               state_d = CONV;
            end else if (dwell_q == DW_MAX && !Hold) begin
               state_d = PICK;
               dwell_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (start)
         refresh_d = Wr_En[snap_ch];
      else if (state_q == CONV || state_q == SHOW)
         refresh_d = refresh_q | Wr_En[rr_q];
      else
         refresh_d = 1'b0;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      ch_d    = ch_q;
      valid_d = valid_q;
      if (cvt_done) begin
         hund_d  = cvt_hund;
         tens_d  = cvt_tens;
         ones_d  = cvt_ones;
         ch_d    = rr_q;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         for (int i = 0; i < NUM_CH; i++) val_q[i] <= '0;
         present_q <= '0;
         rr_q      <= CW'(NUM_CH - 1);
         dwell_q   <= '0;
         refresh_q <= 1'b0;
         recon_q   <= 1'b0;
         hund_q    <= '0;
         tens_q    <= '0;
         ones_q    <= '0;
         ch_q      <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         for (int i = 0; i < NUM_CH; i++) val_q[i] <= val_d[i];
         present_q <= present_d;
         rr_q      <= rr_d;
         dwell_q   <= dwell_d;
         refresh_q <= refresh_d;
         recon_q   <= recon_d;
         hund_q    <= hund_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         ch_q      <= ch_d;
         valid_q   <= valid_d;
      end
   end

   bin2bcd_seq u_bin2bcd (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .start   (start),
      .din     (val_q[snap_ch]),
      .done    (cvt_done),
      .hund    (cvt_hund),
      .tens    (cvt_tens),
      .ones    (cvt_ones)
   );

   assign Bcd_Hund   = hund_q;
   assign Bcd_Tens   = tens_q;
   assign Bcd_Ones   = ones_q;
   assign Disp_Ch    = ch_q;
   assign Disp_Valid = valid_q;
   assign Busy       = (state_q == PICK) || (state_q == CONV);

endmodule

// File: tb/tb_score_display_sched.sv
// Directed self-checking bench for score_display_sched with NUM_CH=4, DWELL=20.
module tb_score_display_sched;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [3:0]  Wr_En;
   logic [31:0] Wr_Data;
   logic        Hold;
   logic [3:0]  Bcd_Hund, Bcd_Tens, Bcd_Ones;
   logic [1:0]  Disp_Ch;
   logic        Disp_Valid, Busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n, t0;
   logic [1:0] prevCh;
   logic chMoved;

   score_display_sched #(.NUM_CH(4), .DWELL(20)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .Wr_En      (Wr_En),
      .Wr_Data    (Wr_Data),
      .Hold       (Hold),
      .Bcd_Hund   (Bcd_Hund),
      .Bcd_Tens   (Bcd_Tens),
      .Bcd_Ones   (Bcd_Ones),
      .Disp_Ch    (Disp_Ch),
      .Disp_Valid (Disp_Valid),
      .Busy       (Busy)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick(input int cycles);
      repeat (cycles) begin
         @(posedge Clk);
         #1;
         cyc++;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] en, input logic [31:0] data);
      Wr_En   = en;
      Wr_Data = data;
      tick(1);
      Wr_En   = '0;
   endtask

   task automatic checkDigits(input string tag, input int h, input int t, input int o, input int ch);
      checkOutput({tag, "_hund"}, Bcd_Hund, h);
      checkOutput({tag, "_tens"}, Bcd_Tens, t);
      checkOutput({tag, "_ones"}, Bcd_Ones, o);
      checkOutput({tag, "_ch"}, Disp_Ch, ch);
   endtask

   task automatic waitChange(input string tag, input int bound, output int waited);
      prevCh = Disp_Ch;
      waited = 0;
      while (Disp_Ch == prevCh && waited < bound) begin
         tick(1);
         waited++;
      end
      checkOutput({tag, "_chMoved"}, 32'(Disp_Ch != prevCh), 1);
   endtask

   task automatic waitValid(input string tag, input int bound);
      int w;
      w = 0;
      while (!Disp_Valid && w < bound) begin
         tick(1);
         w++;
      end
      checkOutput({tag, "_valid"}, Disp_Valid, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Reset_n = 1'b0;
      Wr_En   = '0;
      Wr_Data = '0;
      Hold    = 1'b0;
      #2;
      checkDigits("rst", 0, 0, 0, 0);
      checkOutput("rst_valid", Disp_Valid, 0);
      checkOutput("rst_busy", Busy, 0);
      tick(2);
      Reset_n = 1'b1;
      tick(10);
      checkOutput("idle_busy", Busy, 0);
      checkOutput("idle_valid", Disp_Valid, 0);

      $display("[TB] single channel 255");
      applyStimulus(4'b0100, {8'd0, 8'd255, 8'd0, 8'd0});
      checkOutput("t2_busyEarly", Busy, 0);
      tick(1);
      n = 0;
      while (Busy && n < 20) begin
         n++;
         tick(1);
      end
      checkOutput("t2_busyCycles", n, 9);
      checkDigits("t2", 2, 5, 5, 2);
      checkOutput("t2_valid", Disp_Valid, 1);

      $display("[TB] reset during conversion");
      applyStimulus(4'b0100, {8'd0, 8'd100, 8'd0, 8'd0});
      tick(1);
      checkOutput("t1_busyPre", Busy, 1);
      checkOutput("t1_noFlicker", Bcd_Tens, 5);
      Reset_n = 1'b0;
      #1;
      checkDigits("t1", 0, 0, 0, 0);
      checkOutput("t1_valid", Disp_Valid, 0);
      checkOutput("t1_busy", Busy, 0);
      tick(2);
      Reset_n = 1'b1;
      tick(25);
      checkOutput("t1_idleBusy", Busy, 0);
      checkOutput("t1_idleValid", Disp_Valid, 0);

      $display("[TB] two channels rotating");
      applyStimulus(4'b1001, {8'd200, 8'd0, 8'd0, 8'd7});
      waitValid("t3", 20);
      checkDigits("t3a", 0, 0, 7, 0);
      waitChange("t3b", 40, n);
      checkOutput("t3b_gap", n, 29);
      checkDigits("t3b", 2, 0, 0, 3);
      waitChange("t3c", 40, n);
      checkOutput("t3c_gap", n, 29);
      checkDigits("t3c", 0, 0, 7, 0);

      $display("[TB] refresh of shown channel");
      applyStimulus(4'b0010, {8'd0, 8'd0, 8'd42, 8'd0});
      waitChange("t4a", 40, n);
      checkDigits("t4a", 0, 4, 2, 1);
      t0 = cyc;
      tick(5);
      applyStimulus(4'b0010, {8'd0, 8'd0, 8'd99, 8'd0});
      n = 1;
      while (!(Bcd_Tens == 4'd9 && Bcd_Ones == 4'd9) && n < 15) begin
         tick(1);
         n++;
      end
      checkOutput("t4_refreshWithin10", 32'(n <= 10), 1);
      checkDigits("t4b", 0, 9, 9, 1);
      waitChange("t4c", 40, n);
      checkOutput("t4c_expiry", cyc - t0, 29);
      checkOutput("t4c_ch", Disp_Ch, 3);

      $display("[TB] wrap and skip absent channels");
      Reset_n = 1'b0;
      tick(2);
      Reset_n = 1'b1;
      applyStimulus(4'b1001, {8'd128, 8'd0, 8'd0, 8'd0});
      waitValid("t6", 20);
      checkDigits("t6a", 0, 0, 0, 0);
      waitChange("t6b", 40, n);
      checkDigits("t6b", 1, 2, 8, 3);
      waitChange("t6c", 40, n);
      checkOutput("t6c_gap", n, 29);
      checkDigits("t6c", 0, 0, 0, 0);

      $display("[TB] hold freezes rotation");
      Hold = 1'b1;
      chMoved = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (Disp_Ch != 2'd0) chMoved = 1'b1;
      end
      checkOutput("t5_holdMoved", chMoved, 0);
      checkOutput("t5_holdBusy", Busy, 0);
      Hold = 1'b0;
      waitChange("t5", 20, n);
      checkOutput("t5_releaseWithin10", 32'(n <= 10), 1);
      checkDigits("t5", 1, 2, 8, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
